// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ID/EX pipeline register for the execute-stage ALU. Decodes the ID-stage
// MIPS instruction into the 3-bit ALU operation code, selects operands a/b,
// and registers them with the downstream control bits. Supports hold
// (stall) and bubble insertion (flush); illegal encodings are flagged.

module alu_issue_stage #(
    parameter bit BUBBLE_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        stall,
    input  logic        flush,
    output logic        id_ready,
    output logic        ex_valid,
    output logic [2:0]  ex_aluctr,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_wreg,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_branch,
    output logic        ex_movn,
    output logic        ex_illegal
);

    // ALU operation codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_ADDU = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_MOVN = 3'b111;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_MOVN = 6'h0B;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Contents of one EX slot; all-zero is the bubble.
    typedef struct packed {
        logic        valid;
        logic [2:0]  aluctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store_data;
        logic [4:0]  wreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        movn;
        logic        illegal;
    } ex_slot_t;

    localparam ex_slot_t BUBBLE = '0;

    // Instruction fields
    logic [5:0]  opcode_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [4:0]  shamt_s;
    logic [5:0]  funct_s;
    logic [31:0] imm_se_s;
    logic [31:0] imm_ze_s;
    logic        unused_rs_idx_s;

    assign opcode_s = id_instr[31:26];
    assign rt_s     = id_instr[20:16];
    assign rd_s     = id_instr[15:11];
    assign shamt_s  = id_instr[10:6];
    assign funct_s  = id_instr[5:0];
    assign imm_se_s = {{16{id_instr[15]}}, id_instr[15:0]};
    assign imm_ze_s = {16'h0000, id_instr[15:0]};
    // The rs index is consumed upstream (operand forwarding); only its data arrives here.
    assign unused_rs_idx_s = ^id_instr[25:21];

    ex_slot_t dec_s;
    logic     dec_legal_s;
    ex_slot_t nxt_s;
    ex_slot_t ex_r;

    // Raw decode of the ID instruction into ALU op, operands and control.
    always_comb begin
        dec_s       = BUBBLE;
        dec_legal_s = 1'b1;
        dec_s.valid = 1'b1;
        case (opcode_s)
            OP_RTYPE: begin
                dec_s.a        = id_rs_data;
                dec_s.b        = id_rt_data;
                dec_s.wreg     = rd_s;
                dec_s.regwrite = 1'b1;
                case (funct_s)
                    FN_ADD:  dec_s.aluctr = ALU_ADD;
                    FN_ADDU: dec_s.aluctr = ALU_ADDU;
                    FN_SUB:  dec_s.aluctr = ALU_SUB;
                    FN_AND:  dec_s.aluctr = ALU_AND;
                    FN_OR:   dec_s.aluctr = ALU_OR;
                    FN_SLT:  dec_s.aluctr = ALU_SLT;
                    FN_SLL: begin
                        dec_s.aluctr = ALU_SLL;
                        dec_s.a      = {27'd0, shamt_s};
                    end
                    FN_MOVN: begin
                        dec_s.aluctr = ALU_MOVN;
                        dec_s.movn   = 1'b1;
                    end
                    default: dec_legal_s = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                dec_s.aluctr   = (opcode_s == OP_ADDI)  ? ALU_ADD :
                                 (opcode_s == OP_ADDIU) ? ALU_ADDU : ALU_SLT;
                dec_s.a        = id_rs_data;
                dec_s.b        = imm_se_s;
                dec_s.wreg     = rt_s;
                dec_s.regwrite = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                dec_s.aluctr   = (opcode_s == OP_ANDI) ? ALU_AND : ALU_OR;
                dec_s.a        = id_rs_data;
                dec_s.b        = imm_ze_s;
                dec_s.wreg     = rt_s;
                dec_s.regwrite = 1'b1;
            end
            OP_LUI: begin
                // lui is realised as imm16 << 16 on the shifter.
                dec_s.aluctr   = ALU_SLL;
                dec_s.a        = 32'd16;
                dec_s.b        = imm_ze_s;
                dec_s.wreg     = rt_s;
                dec_s.regwrite = 1'b1;
            end
            OP_LW: begin
                dec_s.aluctr   = ALU_ADDU;
                dec_s.a        = id_rs_data;
                dec_s.b        = imm_se_s;
                dec_s.wreg     = rt_s;
                dec_s.regwrite = 1'b1;
                dec_s.memread  = 1'b1;
            end
            OP_SW: begin
                dec_s.aluctr     = ALU_ADDU;
                dec_s.a          = id_rs_data;
                dec_s.b          = imm_se_s;
                dec_s.wreg       = rt_s;
                dec_s.memwrite   = 1'b1;
                dec_s.store_data = id_rt_data;
            end
            OP_BEQ: begin
                dec_s.aluctr = ALU_SUB;
                dec_s.a      = id_rs_data;
                dec_s.b      = id_rt_data;
                dec_s.wreg   = rt_s;
                dec_s.branch = 1'b1;
            end
            OP_J: begin
                // Jump is resolved earlier; the EX slot just carries a valid no-op.
                dec_s.aluctr = ALU_ADD;
            end
            default: dec_legal_s = 1'b0;
        endcase
    end

    // Slot value to load on an advancing edge: bubble, illegal marker or decoded op.
    always_comb begin
        nxt_s = BUBBLE;
        if (!id_valid) begin
            nxt_s = BUBBLE;
        end else if (!dec_legal_s) begin
            nxt_s         = BUBBLE;
            nxt_s.valid   = !BUBBLE_ON_ILLEGAL;
            nxt_s.illegal = 1'b1;
        end else begin
            nxt_s = dec_s;
            // Writes to $0 are discarded, which also turns 0x00000000 into a nop.
            nxt_s.regwrite = dec_s.regwrite && (dec_s.wreg != 5'd0);
        end
    end

    // EX register: reset > flush > stall (hold) > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r <= BUBBLE;
        end else if (flush) begin
            ex_r <= BUBBLE;
        end else if (stall) begin
            ex_r <= ex_r;
        end else begin
            ex_r <= nxt_s;
        end
    end

    assign id_ready      = !stall;
    assign ex_valid      = ex_r.valid;
    assign ex_aluctr     = ex_r.aluctr;
    assign ex_a          = ex_r.a;
    assign ex_b          = ex_r.b;
    assign ex_store_data = ex_r.store_data;
    assign ex_wreg       = ex_r.wreg;
    assign ex_regwrite   = ex_r.regwrite;
    assign ex_memread    = ex_r.memread;
    assign ex_memwrite   = ex_r.memwrite;
    assign ex_branch     = ex_r.branch;
    assign ex_movn       = ex_r.movn;
    assign ex_illegal    = ex_r.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases then randomized
// traffic, checked against a table-driven reference model.

module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = 32'd0;
    logic [31:0] id_rs_data = 32'd0;
    logic [31:0] id_rt_data = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_ready;
    logic        ex_valid;
    logic [2:0]  ex_aluctr;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_wreg;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_movn, ex_illegal;

    alu_issue_stage #(.BUBBLE_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .stall(stall), .flush(flush),
        .id_ready(id_ready), .ex_valid(ex_valid), .ex_aluctr(ex_aluctr), .ex_a(ex_a),
        .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_wreg(ex_wreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_movn(ex_movn), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [2:0]  ctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  wreg;
        logic        rw, mr, mw, br, mv, ill;
    } slot_t;

    // Operand sources: A_RS, A_SHAMT, A_16, A_ZERO; B_RT, B_SE, B_ZE, B_ZERO; D_RD, D_RT, D_NONE
    typedef struct {
        bit         rtype;
        logic [5:0] code;
        logic [2:0] ctr;
        int         amode;
        int         bmode;
        int         dst;
        bit         rw, mr, mw, br, mv, sd;
    } entry_t;

    entry_t tbl[$];
    slot_t  expq[$];
    slot_t  cur;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     n_popped = 0;

    function automatic logic [31:0] rtyp(input int rs, input int rt, input int rd, input int sh, input int fn);
        logic [31:0] w;
        w = {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
        return w;
    endfunction

    function automatic logic [31:0] ityp(input int op, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
        return w;
    endfunction

    // Reference: look the instruction up in the ISA table and build the slot.
    function automatic slot_t model(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd);
        slot_t  s;
        int     hit;
        entry_t e;
        logic [15:0] imm;
        s   = '0;
        hit = -1;
        imm = ins[15:0];
        foreach (tbl[i]) begin
            if (tbl[i].rtype && ins[31:26] == 6'd0 && ins[5:0] == tbl[i].code) hit = i;
            if (!tbl[i].rtype && ins[31:26] != 6'd0 && ins[31:26] == tbl[i].code) hit = i;
        end
        if (hit < 0) begin
            s.ill = 1'b1;
            return s;
        end
        e = tbl[hit];
        s.valid = 1'b1;
        s.ctr   = e.ctr;
        case (e.amode)
            0: s.a = rsd;
            1: s.a = 32'(ins[10:6]);
            2: s.a = 32'd16;
            default: s.a = 32'd0;
        endcase
        case (e.bmode)
            0: s.b = rtd;
            1: s.b = 32'($signed(imm));
            2: s.b = 32'(imm);
            default: s.b = 32'd0;
        endcase
        case (e.dst)
            0: s.wreg = ins[15:11];
            1: s.wreg = ins[20:16];
            default: s.wreg = 5'd0;
        endcase
        s.rw = e.rw && (s.wreg != 5'd0);
        s.mr = e.mr;
        s.mw = e.mw;
        s.br = e.br;
        s.mv = e.mv;
        s.sd = e.sd ? rtd : 32'd0;
        return s;
    endfunction

    function automatic void add_e(input bit rt, input int code, input int ctr, input int am,
                                  input int bm, input int dst, input bit rw, input bit mr,
                                  input bit mw, input bit br, input bit mv, input bit sd);
        entry_t e;
        e.rtype = rt; e.code = code[5:0]; e.ctr = ctr[2:0];
        e.amode = am; e.bmode = bm; e.dst = dst;
        e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.mv = mv; e.sd = sd;
        tbl.push_back(e);
    endfunction

    // Apply one cycle of inputs, record the slot expected after the coming edge.
    task automatic step(input bit r, input bit v, input logic [31:0] ins,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input bit st, input bit fl);
        rst = r; id_valid = v; id_instr = ins; id_rs_data = rsd; id_rt_data = rtd;
        stall = st; flush = fl;
        if (r || fl)      cur = '0;
        else if (st)      cur = cur;
        else if (v)       cur = model(ins, rsd, rtd);
        else              cur = '0;
        expq.push_back(cur);
        #1;
        n_tests++;
        if (id_ready !== !st) begin
            n_fail++;
            $display("FAIL id_ready: got %b expected %b", id_ready, !st);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents a slot; compare with the oldest expectation.
    initial begin : monitor
        slot_t got, exp_s;
        forever begin
            @(posedge clk);
            @(negedge clk);
            if (expq.size() > 0) begin
                exp_s = expq.pop_front();
                got = '{ex_valid, ex_aluctr, ex_a, ex_b, ex_store_data, ex_wreg,
                        ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_movn, ex_illegal};
                n_tests++;
                n_popped++;
                if (got !== exp_s) begin
                    n_fail++;
                    $display("FAIL slot#%0d: got v=%b op=%b a=%h b=%h sd=%h wr=%0d rw=%b mr=%b mw=%b br=%b mv=%b ill=%b | expected v=%b op=%b a=%h b=%h sd=%h wr=%0d rw=%b mr=%b mw=%b br=%b mv=%b ill=%b",
                             n_popped, got.valid, got.ctr, got.a, got.b, got.sd, got.wreg, got.rw,
                             got.mr, got.mw, got.br, got.mv, got.ill,
                             exp_s.valid, exp_s.ctr, exp_s.a, exp_s.b, exp_s.sd, exp_s.wreg, exp_s.rw,
                             exp_s.mr, exp_s.mw, exp_s.br, exp_s.mv, exp_s.ill);
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] w;
        logic [31:0] rsd, rtd;
        int k;
        //    rt  code   ctr am bm dst rw mr mw br mv sd
        add_e(1, 'h20, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add_e(1, 'h21, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add_e(1, 'h22, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add_e(1, 'h24, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add_e(1, 'h25, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add_e(1, 'h2A, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add_e(1, 'h00, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add_e(1, 'h0B, 7, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        add_e(0, 'h08, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        add_e(0, 'h09, 5, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        add_e(0, 'h0A, 6, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        add_e(0, 'h0C, 4, 0, 2, 1, 1, 0, 0, 0, 0, 0);
        add_e(0, 'h0D, 3, 0, 2, 1, 1, 0, 0, 0, 0, 0);
        add_e(0, 'h0F, 2, 2, 2, 1, 1, 0, 0, 0, 0, 0);
        add_e(0, 'h23, 5, 0, 1, 1, 1, 1, 0, 0, 0, 0);
        add_e(0, 'h2B, 5, 0, 1, 1, 0, 0, 1, 0, 0, 1);
        add_e(0, 'h04, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        add_e(0, 'h02, 0, 3, 3, 2, 0, 0, 0, 0, 0, 0);
        cur = '0;

        // Reset with garbage on the ID side, then idle.
        step(1, 1, $urandom, $urandom, $urandom, 0, 0);
        step(1, 1, $urandom, $urandom, $urandom, 0, 0);
        step(0, 0, $urandom, $urandom, $urandom, 0, 0);
        step(0, 0, $urandom, $urandom, $urandom, 0, 0);

        // R-type sweep: add, addu, sub, and, or, slt, movn.
        step(0, 1, rtyp(1, 2, 3, 0, 'h20), 32'h7FFFFFFF, 32'h1, 0, 0);
        step(0, 1, rtyp(1, 2, 3, 0, 'h21), 32'h7FFFFFFF, 32'h1, 0, 0);
        step(0, 1, rtyp(1, 2, 3, 0, 'h22), 32'h7FFFFFFF, 32'h1, 0, 0);
        step(0, 1, rtyp(1, 2, 3, 0, 'h24), 32'h7FFFFFFF, 32'h1, 0, 0);
        step(0, 1, rtyp(1, 2, 3, 0, 'h25), 32'h7FFFFFFF, 32'h1, 0, 0);
        step(0, 1, rtyp(1, 2, 3, 0, 'h2A), 32'h7FFFFFFF, 32'h1, 0, 0);
        step(0, 1, rtyp(1, 2, 3, 0, 'h0B), 32'h7FFFFFFF, 32'h1, 0, 0);

        // Shift, lui, immediate extension, store.
        step(0, 1, rtyp(0, 5, 4, 7, 'h00), 32'h12345678, 32'h1, 0, 0);
        step(0, 1, ityp('h0F, 0, 6, 'hABCD), 32'h55555555, 32'h66666666, 0, 0);
        step(0, 1, ityp('h08, 0, 1, 'hFFFF), 32'h0, 32'h0, 0, 0);
        step(0, 1, ityp('h0D, 0, 1, 'hFFFF), 32'h0, 32'h0, 0, 0);
        step(0, 1, ityp('h2B, 3, 2, 'hFFFC), 32'h1000, 32'hDEAD, 0, 0);

        // Stall holds through input churn; stall+flush yields a bubble.
        step(0, 1, rtyp(1, 2, 3, 0, 'h20), 32'h11, 32'h22, 0, 0);
        step(0, 1, ityp('h0D, 7, 8, 'h1234), 32'hAAAA, 32'hBBBB, 1, 0);
        step(0, 1, rtyp(9, 9, 9, 0, 'h22), 32'hCCCC, 32'hDDDD, 1, 0);
        step(0, 0, ityp('h23, 1, 1, 'h0004), 32'hEEEE, 32'hFFFF, 1, 0);
        step(0, 1, rtyp(1, 2, 3, 0, 'h20), 32'h11, 32'h22, 1, 1);
        step(0, 0, 32'd0, 32'd0, 32'd0, 0, 0);

        // nop word, illegal opcode, then a normal ori.
        step(0, 1, 32'h00000000, 32'h0, 32'h5, 0, 0);
        step(0, 1, ityp('h3F, 1, 2, 'h1111), 32'h3, 32'h4, 0, 0);
        step(0, 1, ityp('h0D, 0, 1, 'h00F0), 32'h0, 32'h0, 0, 0);
        step(0, 1, rtyp(1, 2, 3, 0, 'h3F), 32'h3, 32'h4, 0, 0);
        step(0, 1, rtyp(1, 2, 0, 0, 'h20), 32'h3, 32'h4, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) != 0) begin
                k = $urandom_range(0, tbl.size() - 1);
                w = $urandom;
                if (tbl[k].rtype) w = {6'd0, w[25:6], tbl[k].code};
                else              w = {tbl[k].code, w[25:0]};
            end else begin
                w = $urandom;
            end
            rsd = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            rtd = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            step($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0, w, rsd, rtd,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end
        step(0, 0, 32'd0, 32'd0, 32'd0, 0, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline stage that drives the execute-stage ALU. It decodes the ID-stage instruction into the ALU's 3-bit `aluctr` encoding and selects operands `a`/`b`. It registers them together with the downstream control bits, and supports hold (stall) and bubble-insert (flush) so the ALU sees stable, well-formed inputs every cycle.

## Interface
Parameters:
- `BUBBLE_ON_ILLEGAL`, default 1: 1 = an unsupported opcode or funct loads a bubble and pulses `ex_illegal`; 0 = it loads with `ex_illegal`=1 but all control bits 0.

Ports:
- Clock is `clk` and reset is `rst`: one clock, synchronous active-high reset.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `id_valid`, in, 1: `id_instr` and the operand data are valid this cycle.
- `id_instr`, in, 32: MIPS instruction word.
- `id_rs_data`, in, 32: forwarded rs value.
- `id_rt_data`, in, 32: forwarded rt value.
- `stall`, in, 1: hold the EX register.
- `flush`, in, 1: load a bubble.
- `id_ready`, out, 1: combinational, equals `!stall`. ID advances only when `id_valid && id_ready`.
- `ex_valid`, out, 1: the EX slot holds a real instruction.
- `ex_aluctr`, out, 3: ALU operation code.
- `ex_a`, out, 32: ALU operand a.
- `ex_b`, out, 32: ALU operand b.
- `ex_store_data`, out, 32: rt value for `sw`.
- `ex_wreg`, out, 5: destination register.
- `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_branch`, `ex_movn`, out, 1 each: downstream control.
- `ex_illegal`, out, 1: the EX slot holds an undecodable instruction.

## Operation
ALU encoding:
- 000: add, signed.
- 001: sub.
- 010: `b << a`.
- 011: or.
- 100: and.
- 101: addu.
- 110: slt.
- 111: movn (res = a when b != 0).

Decode for opcode 0 (R-type). For all of these, a = rs, b = rt, wreg = rd, regwrite = 1 unless noted.
- funct 0x20 add → 000.
- funct 0x21 addu → 101.
- funct 0x22 sub → 001.
- funct 0x24 and → 100.
- funct 0x25 or → 011.
- funct 0x2A slt → 110.
- funct 0x00 sll → 010, with a = zero-extended shamt and b = rt.
- funct 0x0B movn → 111, with `ex_movn` = 1.

I-type decode uses wreg = rt and regwrite = 1 unless noted. SE = sign-extended imm16, ZE = zero-extended imm16.
- addi 0x08 → 000, a = rs, b = SE.
- addiu 0x09 → 101, a = rs, b = SE.
- slti 0x0A → 110, a = rs, b = SE.
- andi 0x0C → 100, a = rs, b = ZE.
- ori 0x0D → 011, a = rs, b = ZE.
- lui 0x0F → 010, a = 16, b = ZE.
- lw 0x23 → 101, a = rs, b = SE, memread = 1.
- sw 0x2B → 101, a = rs, b = SE, memwrite = 1, regwrite = 0, store_data = rt.
- beq 0x04 → 001, a = rs, b = rt, branch = 1, regwrite = 0.
- j 0x02 → valid, all control 0, aluctr 000, a = b = 0.

Other rules:
- Any other opcode or funct is illegal.
- Destination 0 forces `ex_regwrite` = 0. This makes instruction 0x00000000 an effective nop with `ex_valid` = 1.
- Bubble contents: `ex_valid` = 0, all control bits 0, `ex_aluctr` = 000, `ex_a` = `ex_b` = `ex_store_data` = 0, `ex_wreg` = 0, `ex_illegal` = 0.
- `id_valid` = 0 with no stall or flush loads a bubble.

## Timing
- Register priority each rising edge: `rst` > `flush` > `stall` > load.
- `rst`: all `ex_*` outputs become the bubble values, including `ex_illegal` = 0. Reset values take effect on the first edge with `rst` = 1, and reset mid-stall discards the held instruction.
- `flush` (with or without `stall`): bubble next cycle. Flush beats stall.
- `stall` with no flush: every `ex_*` output holds bit-for-bit. Input changes during the stall are ignored, and `id_ready` = 0 that cycle.
- Load: decoded values appear on `ex_*` one cycle after the edge where `id_valid && !stall && !flush`. Latency is exactly 1 and throughput is 1 instruction per cycle.
- Illegal with `BUBBLE_ON_ILLEGAL` = 1: `ex_valid` = 0 and `ex_illegal` = 1 for that one slot only. The next load or bubble clears it.
- Operand capture: `id_rs_data` and `id_rt_data` are sampled at the load edge, not while stalled.
- No combinational path from `id_*` to `ex_*`. The only combinational output is `id_ready`.

## Test plan
- Reset then idle: `rst` = 1 for 2 cycles with a random `id_instr` → all `ex_*` are 0 and `ex_aluctr` = 000. After release with `id_valid` = 0, they stay 0.
- R-type sweep: `add $3,$1,$2` with rs = 0x7FFFFFFF and rt = 1 → next cycle `ex_aluctr` = 000, a = 0x7FFFFFFF, b = 1, wreg = 3, regwrite = 1. Repeat for addu/sub/and/or/slt/movn and check codes 101/001/100/011/110/111 with `ex_movn` = 1 only for movn.
- Shift and lui: `sll $4,$5,7` with rt = 0x1 → aluctr 010, a = 7, b = 1, wreg = 4. `lui $6,0xABCD` → aluctr 010, a = 16, b = 0x0000ABCD, wreg = 6.
- Immediate extension: `addi $1,$0,0xFFFF` → b = 0xFFFFFFFF. `ori $1,$0,0xFFFF` → b = 0x0000FFFF. `sw $2,-4($3)` with rt = 0xDEAD → aluctr 101, b = 0xFFFFFFFC, memwrite = 1, regwrite = 0, store_data = 0xDEAD.
- Stall and flush: load add, then assert `stall` 3 cycles while `id_instr` and rs change → outputs unchanged and `id_ready` = 0. Then assert `stall` and `flush` together → bubble next cycle.
- Edge cases: 0x00000000 → `ex_valid` = 1, regwrite = 0. Opcode 0x3F → one-cycle `ex_illegal` = 1 with `ex_valid` = 0, then a following `ori` loads normally with `ex_illegal` = 0.
